// File: rtl/pipe_valid_tracker.sv
// Valid-bit tracker that runs in lock-step with the AES round pipeline.
// Shifts an in_valid token through NUM_STAGES slots, keeps a running
// occupancy count and reports full/empty/drain-done status.
module pipe_valid_tracker #(
  parameter int NUM_STAGES   = 40,
  parameter int NUM_CNT_BITS = 6
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    stall,
  input  logic                    in_valid,
  output logic                    out_valid,
  output logic [NUM_CNT_BITS-1:0] occupancy,
  output logic                    full_flag,
  output logic                    empty_flag,
  output logic                    drain_done
);

  // Reject depths that cannot shift or counts too narrow to reach NUM_STAGES.
  if (NUM_STAGES < 2) begin : g_bad_depth
    $error("pipe_valid_tracker: NUM_STAGES must be >= 2");
  end
  if ((2 ** NUM_CNT_BITS) <= NUM_STAGES) begin : g_bad_width
    $error("pipe_valid_tracker: 2**NUM_CNT_BITS must exceed NUM_STAGES");
  end

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] CNT_FULL = NUM_CNT_BITS'(NUM_STAGES);

  logic [NUM_STAGES-1:0]   r_valid_sr;   // bit 0 = entry stage
  logic [NUM_CNT_BITS-1:0] r_occ;
  logic                    r_drain;
  logic [NUM_CNT_BITS-1:0] w_occ_nxt;
  logic                    w_exit;

  assign w_exit = r_valid_sr[NUM_STAGES-1];

  // Occupancy after an advance edge: +1 on entry, -1 on exit, unchanged when
  // both happen together. A full pipe always exits, so it never overflows.
  always_comb begin
    w_occ_nxt = r_occ;
    if (in_valid && !w_exit)      w_occ_nxt = r_occ + CNT_ONE;
    else if (!in_valid && w_exit) w_occ_nxt = r_occ - CNT_ONE;
  end

  // Token shift register, occupancy and drain pulse; clear beats stall beats advance.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid_sr <= '0;
      r_occ      <= '0;
      r_drain    <= 1'b0;
    end else if (clear) begin
      r_valid_sr <= '0;
      r_occ      <= '0;
      r_drain    <= (r_occ == CNT_ONE);
    end else if (stall) begin
      r_drain    <= 1'b0;
    end else begin
      r_valid_sr <= {r_valid_sr[NUM_STAGES-2:0], in_valid};
      r_occ      <= w_occ_nxt;
      r_drain    <= (r_occ == CNT_ONE) && (w_occ_nxt == '0);
    end
  end

  assign out_valid  = w_exit;
  assign occupancy  = r_occ;
  assign full_flag  = (r_occ == CNT_FULL);
  assign empty_flag = (r_occ == '0);
  assign drain_done = r_drain;

endmodule

// File: tb/tb_pipe_valid_tracker.sv
// Bench for pipe_valid_tracker: a 40-stage and a 4-stage instance, each with
// a timestamp scoreboard (expected exit advance-count per token) and a
// negedge monitor, plus directed hand-computed checks.
module tb_pipe_valid_tracker;

  logic clk;
  logic n_rst;
  logic clr [2];
  logic stl [2];
  logic vin [2];

  int n_chk;
  int n_pass;

  // Compare one value and log a FAIL line on mismatch.
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int NS = (g == 0) ? 40 : 4;
    localparam int W  = (g == 0) ? 6 : 3;

    logic         ov;
    logic [W-1:0] occ;
    logic         ff;
    logic         ef;
    logic         dd;

    pipe_valid_tracker #(.NUM_STAGES(NS), .NUM_CNT_BITS(W)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clr[g]),
      .stall     (stl[g]),
      .in_valid  (vin[g]),
      .out_valid (ov),
      .occupancy (occ),
      .full_flag (ff),
      .empty_flag(ef),
      .drain_done(dd)
    );

    // Scoreboard: each in-flight token holds the advance count at which it
    // must be visible on out_valid (entry advance + NS - 1).
    int q[$];
    int adv;
    bit exp_dd;

    // Reference model, updated on the same edges as the DUT.
    always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        q.delete();
        adv    = 0;
        exp_dd = 0;
      end else begin
        int prev;
        prev = q.size();
        if (clr[g]) begin
          q.delete();
          exp_dd = (prev == 1);
        end else if (stl[g]) begin
          exp_dd = 0;
        end else begin
          if (q.size() > 0 && q[0] == adv) void'(q.pop_front());
          adv++;
          if (vin[g]) q.push_back(adv + NS - 1);
          exp_dd = (prev == 1) && (q.size() == 0);
        end
      end
    end

    // Monitor: compare DUT outputs against the scoreboard away from the edge.
    always @(negedge clk) begin
      if (n_rst) begin
        bit due;
        due = (q.size() > 0) && (q[0] == adv);
        chk($sformatf("m%0d_out_valid", g), int'(ov), int'(due));
        chk($sformatf("m%0d_occupancy", g), int'(occ), q.size());
        chk($sformatf("m%0d_full", g), int'(ff), int'(q.size() == NS));
        chk($sformatf("m%0d_empty", g), int'(ef), int'(q.size() == 0));
        chk($sformatf("m%0d_drain", g), int'(dd), int'(exp_dd));
        chk($sformatf("m%0d_occ_le_depth", g), int'(int'(occ) <= NS), 1);
      end
    end
  end

  // One clock of stimulus on instance i; returns 1 time unit after the edge.
  task automatic cyc(input int i, input bit c, input bit s, input bit v);
    clr[i] = c;
    stl[i] = s;
    vin[i] = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    n_chk  = 0;
    n_pass = 0;
    clk    = 0;
    n_rst  = 0;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 0;
      stl[i] = 0;
      vin[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(ch[0].ov), 0);
    chk("rst_empty", int'(ch[0].ef), 1);
    chk("rst_full", int'(ch[0].ff), 0);
    chk("rst_drain", int'(ch[0].dd), 0);
    n_rst = 1;
    cyc(0, 0, 0, 0);

    // Single token: visible after its 40th edge, drain pulse one edge later.
    cyc(0, 0, 0, 1);
    chk("t2_occ_entry", int'(ch[0].occ), 1);
    for (int e = 2; e <= 40; e++) begin
      cyc(0, 0, 0, 0);
      if (e == 39) chk("t2_ov_e39", int'(ch[0].ov), 0);
    end
    chk("t2_ov_e40", int'(ch[0].ov), 1);
    chk("t2_occ_e40", int'(ch[0].occ), 1);
    cyc(0, 0, 0, 0);
    chk("t2_ov_e41", int'(ch[0].ov), 0);
    chk("t2_occ_e41", int'(ch[0].occ), 0);
    chk("t2_drain_e41", int'(ch[0].dd), 1);
    cyc(0, 0, 0, 0);
    chk("t2_drain_e42", int'(ch[0].dd), 0);

    // Continuous streaming then drain.
    for (int e = 1; e <= 60; e++) begin
      cyc(0, 0, 0, 1);
      if (e == 39) chk("t3_full_e39", int'(ch[0].ff), 0);
      if (e == 40) chk("t3_full_e40", int'(ch[0].ff), 1);
    end
    chk("t3_occ_e60", int'(ch[0].occ), 40);
    chk("t3_ov_e60", int'(ch[0].ov), 1);
    pulses = 0;
    for (int e = 1; e <= 42; e++) begin
      cyc(0, 0, 0, 0);
      if (ch[0].dd) pulses++;
      if (e == 20) chk("t3_occ_drain20", int'(ch[0].occ), 20);
    end
    chk("t3_occ_drained", int'(ch[0].occ), 0);
    chk("t3_drain_pulses", pulses, 1);

    // Three tokens, five stall cycles with in_valid held high.
    for (int e = 1; e <= 3; e++) cyc(0, 0, 0, 1);
    for (int e = 4; e <= 8; e++) begin
      cyc(0, 0, 1, 1);
      chk("t4_occ_stall", int'(ch[0].occ), 3);
    end
    for (int e = 9; e <= 45; e++) begin
      cyc(0, 0, 0, 0);
      if (e == 44) chk("t4_ov_e44", int'(ch[0].ov), 0);
    end
    chk("t4_ov_e45", int'(ch[0].ov), 1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("t4_occ_done", int'(ch[0].occ), 0);

    // clear+stall+in_valid at occupancy 1 and 5.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 1);
    chk("t5_occ_clr1", int'(ch[0].occ), 0);
    chk("t5_drain_clr1", int'(ch[0].dd), 1);
    chk("t5_ov_clr1", int'(ch[0].ov), 0);
    for (int e = 1; e <= 5; e++) cyc(0, 0, 0, 1);
    chk("t5_occ_pre5", int'(ch[0].occ), 5);
    cyc(0, 1, 1, 1);
    chk("t5_occ_clr5", int'(ch[0].occ), 0);
    chk("t5_drain_clr5", int'(ch[0].dd), 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-stream at occupancy 17.
    for (int e = 1; e <= 17; e++) cyc(0, 0, 0, 1);
    chk("t1_occ_pre", int'(ch[0].occ), 17);
    #2 n_rst = 0;
    #1;
    chk("t1_occ_rst", int'(ch[0].occ), 0);
    chk("t1_empty_rst", int'(ch[0].ef), 1);
    chk("t1_full_rst", int'(ch[0].ff), 0);
    chk("t1_drain_rst", int'(ch[0].dd), 0);
    chk("t1_ov_rst", int'(ch[0].ov), 0);
    vin[0] = 0;
    #1 n_rst = 1;
    cyc(0, 0, 0, 0);

    // Random traffic on the 4-stage instance; the monitor does the checking.
    for (int e = 0; e < 10000; e++)
      cyc(1, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));
    repeat (6) cyc(1, 0, 0, 0);
    chk("t6_occ_final", int'(ch[1].occ), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
